// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between playback (0) and recording (1).
// Define SDRAM_ARB_TIMEOUT_EN to build the ACCESS watchdog that aborts after TIMEOUT_CYCLES.
module sdram_arbiter #(
  parameter int ADDR_W         = 23,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              play_read,
  input  logic [ADDR_W-1:0] play_addr,
  output logic [DATA_W-1:0] play_readdata,
  output logic              play_sdram_finished,
  input  logic              play_sdram_refresh,
  input  logic              rec_read,
  input  logic              rec_write,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic [DATA_W-1:0] rec_writedata,
  output logic [DATA_W-1:0] rec_readdata,
  output logic              rec_sdram_finished,
  input  logic              rec_sdram_refresh,
  output logic              sdram_read,
  output logic              sdram_write,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_writedata,
  input  logic [DATA_W-1:0] sdram_readdata,
  input  logic              sdram_finished,
  output logic              sdram_refresh,
  output logic              arb_owner,
  output logic              arb_timeout
);

  typedef enum logic [1:0] {IDLE, REFRESH, ACCESS, DONE} state_t;

  state_t state;
  logic   last_owner;
  logic   cmd_rd;
  logic   cmd_wr;
  logic   req0;
  logic   req1;
  logic   next_owner;
  logic   need_refresh;

  assign req0 = play_read;
  assign req1 = rec_read | rec_write;

  // On a tie the requester that did not go last wins; a change of owner always forces a refresh.
  assign next_owner   = (req0 && req1) ? ~last_owner : req1;
  assign need_refresh = (next_owner != last_owner) ||
                        (next_owner ? rec_sdram_refresh : play_sdram_refresh);

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] access_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= IDLE;
      last_owner          <= 1'b1;
      cmd_rd              <= 1'b0;
      cmd_wr              <= 1'b0;
      arb_owner           <= 1'b0;
      sdram_read          <= 1'b0;
      sdram_write         <= 1'b0;
      sdram_refresh       <= 1'b0;
      sdram_addr          <= '0;
      sdram_writedata     <= '0;
      play_readdata       <= '0;
      rec_readdata        <= '0;
      play_sdram_finished <= 1'b0;
      rec_sdram_finished  <= 1'b0;
      arb_timeout         <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
      access_cnt          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            arb_owner       <= next_owner;
            sdram_addr      <= next_owner ? rec_addr : play_addr;
            sdram_writedata <= next_owner ? rec_writedata : '0;
            // Write beats read when the recorder raises both.
            cmd_wr          <= next_owner & rec_write;
            cmd_rd          <= ~(next_owner & rec_write);
            if (need_refresh) begin
              sdram_refresh <= 1'b1;
              state         <= REFRESH;
            end else begin
              sdram_read    <= ~(next_owner & rec_write);
              sdram_write   <= next_owner & rec_write;
              state         <= ACCESS;
`ifdef SDRAM_ARB_TIMEOUT_EN
              access_cnt    <= '0;
`endif
            end
          end
        end
        REFRESH: begin
          sdram_refresh <= 1'b0;
          sdram_read    <= cmd_rd;
          sdram_write   <= cmd_wr;
          state         <= ACCESS;
`ifdef SDRAM_ARB_TIMEOUT_EN
          access_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (sdram_finished) begin
            sdram_read  <= 1'b0;
            sdram_write <= 1'b0;
            last_owner  <= arb_owner;
            if (arb_owner) begin
              rec_readdata       <= sdram_readdata;
              rec_sdram_finished <= 1'b1;
            end else begin
              play_readdata       <= sdram_readdata;
              play_sdram_finished <= 1'b1;
            end
            state <= DONE;
          end
`ifdef SDRAM_ARB_TIMEOUT_EN
          else if (access_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            sdram_read  <= 1'b0;
            sdram_write <= 1'b0;
            last_owner  <= arb_owner;
            arb_timeout <= 1'b1;
            if (arb_owner) begin
              rec_readdata       <= '0;
              rec_sdram_finished <= 1'b1;
            end else begin
              play_readdata       <= '0;
              play_sdram_finished <= 1'b1;
            end
            state <= DONE;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          play_sdram_finished <= 1'b0;
          rec_sdram_finished  <= 1'b0;
          arb_timeout         <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
